// File: rtl/dense_out_argmax_if.sv
// Result handshake bundle for dense_out_argmax.
// master drives the class result, slave returns ready.
interface dense_out_argmax_if #(
    parameter int IDX_W = 6,
    parameter int IN_W  = 40
);
    logic                    result_valid;
    logic                    result_ready;
    logic [IDX_W-1:0]        class_idx;
    logic signed [IN_W-1:0]  class_score;

    modport master (
        output result_valid,
        output class_idx,
        output class_score,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  class_idx,
        input  class_score,
        output result_ready
    );
endinterface

// File: rtl/dense_out_argmax.sv
// Argmax over the final dense layer outputs.
// Snapshots the vector, scans one element per clock, hands off the winner.
module dense_out_argmax #(
    parameter int OUT_SIZE = 64,
    parameter int IN_W     = 40,
    parameter int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [IN_W-1:0] output_vector [0:OUT_SIZE-1],
    output logic                   busy,
    dense_out_argmax_if.master     res
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_SIZE - 1);

    logic [1:0]             state;
    logic signed [IN_W-1:0] snap [0:OUT_SIZE-1];
    logic signed [IN_W-1:0] best;
    logic [IDX_W-1:0]       best_idx;
    logic [IDX_W-1:0]       ptr;
    logic signed [IN_W-1:0] cand;

    assign cand = snap[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            best     <= '0;
            best_idx <= '0;
            ptr      <= '0;
            for (int i = 0; i < OUT_SIZE; i++)
                snap[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < OUT_SIZE; i++)
                            snap[i] <= output_vector[i];
                        best     <= output_vector[0];
                        best_idx <= '0;
                        ptr      <= IDX_W'(1);
                        state    <= (OUT_SIZE == 1) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    // strict compare keeps the lower index on ties
                    if (cand > best) begin
                        best     <= cand;
                        best_idx <= ptr;
                    end
                    if (ptr == LAST)
                        state <= DONE;
                    else
                        ptr <= ptr + IDX_W'(1);
                end
                DONE: begin
                    if (res.result_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign res.result_valid = (state == DONE);
    assign res.class_idx    = best_idx;
    assign res.class_score  = best;

endmodule

// File: tb/tb_dense_out_argmax.sv
// Randomised scoreboard bench for dense_out_argmax.
// Expected winners come from a first-maximum reference over plain arrays.
module tb_dense_out_argmax;

    localparam int N  = 64;
    localparam int W  = 40;
    localparam int IW = 6;

    typedef logic signed [W-1:0] elem_t;
    typedef struct {
        int    idx;
        elem_t score;
    } exp_t;

    logic  clk;
    logic  rst;
    logic  start;
    logic  busy;
    logic  rdy;
    elem_t ov [0:N-1];

    dense_out_argmax_if #(.IDX_W(IW), .IN_W(W)) res_if ();

    assign res_if.result_ready = rdy;

    dense_out_argmax #(
        .OUT_SIZE(N),
        .IN_W    (W),
        .IDX_W   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .output_vector(ov),
        .busy         (busy),
        .res          (res_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_fail;
    int   hs_cnt;
    bit   rand_rdy;
    exp_t sb[$];

    elem_t v   [0:N-1];
    elem_t alt [0:N-1];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference: find the maximum value, then the first index holding it
    function automatic exp_t ref_argmax(input elem_t a [0:N-1]);
        exp_t  e;
        elem_t mx;
        mx = a[0];
        foreach (a[i]) if (a[i] > mx) mx = a[i];
        e.score = mx;
        e.idx   = -1;
        foreach (a[i]) if (e.idx < 0 && a[i] == mx) e.idx = i;
        return e;
    endfunction

    function automatic elem_t rnd_elem(input int mode);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (mode == 0)
            return elem_t'($urandom_range(0, 8)) - elem_t'(4);
        if (mode == 2 && $urandom_range(0, 3) == 0)
            return {1'b1, {(W-1){1'b0}}};
        return r[W-1:0];
    endfunction

    // monitor: pops on every handshake, checks hold stability and pulse width
    initial begin : monitor
        bit    held;
        bit    prev_hs;
        int    h_idx;
        elem_t h_score;
        exp_t  e;
        held    = 0;
        prev_hs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held    = 0;
                prev_hs = 0;
            end else begin
                if (prev_hs)
                    chk("valid_one_cycle", 64'(res_if.result_valid), 64'd0);
                if (held && res_if.result_valid) begin
                    chk("hold_idx", 64'(res_if.class_idx), 64'(h_idx));
                    chk("hold_score", 64'(res_if.class_score), 64'(h_score));
                end
                prev_hs = 0;
                held    = 0;
                if (res_if.result_valid && rdy) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'd1, 64'(sb.size()));
                    end else begin
                        e = sb.pop_front();
                        chk("class_idx", 64'(res_if.class_idx), 64'(e.idx));
                        chk("class_score", 64'(res_if.class_score),
                            64'(e.score));
                    end
                    hs_cnt++;
                    prev_hs = 1;
                end else if (res_if.result_valid) begin
                    held    = 1;
                    h_idx   = int'(res_if.class_idx);
                    h_score = res_if.class_score;
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        end
    end

    // start a scan of v; optionally swap in alt at a given cycle of the scan
    task automatic launch(input int alt_at);
        int lat;
        bit seen;
        sb.push_back(ref_argmax(v));
        ov    = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        seen  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (res_if.result_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            if (lat == alt_at) ov = alt;
        end
        chk("latency", seen ? 64'(lat) : 64'hFFFF, 64'(N));
    endtask

    task automatic finish_hs(input int h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 500; k++) begin
            if (hs_cnt > h0) break;
            @(posedge clk);
            #1;
        end
        chk("handshake", 64'(hs_cnt), 64'(h0 + 1));
        chk("busy_after_hs", 64'(busy), 64'd0);
    endtask

    task automatic run(input int alt_at);
        int h0;
        h0 = hs_cnt;
        launch(alt_at);
        finish_hs(h0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int h0;
        n_chk    = 0;
        n_fail   = 0;
        hs_cnt   = 0;
        rand_rdy = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rdy      = 1'b1;
        foreach (ov[i]) ov[i] = elem_t'(i + 100);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(res_if.result_valid), 64'd0);
        chk("rst_idx", 64'(res_if.class_idx), 64'd0);
        chk("rst_score", 64'(res_if.class_score), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (v[i]) v[i] = elem_t'(i);
        run(-1);

        foreach (v[i]) v[i] = -elem_t'(i + 1);
        v[17] = -elem_t'(1);
        v[0]  = -elem_t'(2);
        run(-1);

        foreach (v[i]) v[i] = '0;
        v[5]  = elem_t'(1000);
        v[40] = elem_t'(1000);
        run(-1);

        foreach (v[i]) v[i] = {1'b1, {(W-1){1'b0}}};
        v[N-1] = {1'b1, {(W-2){1'b0}}, 1'b1};
        run(-1);

        // backpressure with an ignored start while the result is held
        foreach (v[i]) v[i] = rnd_elem(1);
        foreach (alt[i]) alt[i] = '0;
        alt[3] = {1'b0, {(W-1){1'b1}}};
        rdy = 1'b0;
        h0  = hs_cnt;
        launch(-1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                ov    = alt;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("bp_still_valid", 64'(res_if.result_valid), 64'd1);
        chk("bp_no_hs", 64'(hs_cnt), 64'(h0));
        rdy = 1'b1;
        finish_hs(h0);

        // input change after the start edge must not matter
        foreach (v[i]) v[i] = rnd_elem(0);
        alt = v;
        alt[9] = elem_t'(5000);
        run(2);

        // reset in the middle of a scan
        foreach (v[i]) v[i] = elem_t'(i);
        ov    = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(res_if.result_valid), 64'd0);
        chk("midrst_idx", 64'(res_if.class_idx), 64'd0);
        chk("midrst_score", 64'(res_if.class_score), 64'd0);
        foreach (v[i]) v[i] = elem_t'($urandom_range(0, 50));
        v[2] = elem_t'(77);
        run(-1);

        // random vectors under random backpressure
        rand_rdy = 1;
        for (int t = 0; t < 12; t++) begin
            foreach (v[i]) v[i] = rnd_elem(t % 3);
            run(-1);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
